// File: rtl/btb_ctrl.sv
// Branch target buffer controller: fetch lookup, buffered execute-stage
// updates draining into an external direct-mapped array, and an index-walking flush FSM.
module btb_ctrl #(
    parameter int unsigned width     = 32,
    parameter int unsigned bit_entry = 3,
    parameter int unsigned fifo_log2 = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [width-1:0]               lkp_pc,
    output logic                           pred_hit,
    output logic [width-1:0]               pred_target,
    input  logic                           upd_valid,
    output logic                           upd_ready,
    input  logic [width-1:0]               upd_pc,
    input  logic [width-1:0]               upd_target,
    input  logic                           upd_taken,
    input  logic                           flush_req,
    output logic                           busy,
    output logic                           arr_load,
    output logic [bit_entry-1:0]           arr_r_index,
    output logic [bit_entry-1:0]           arr_w_index,
    output logic [2*width-bit_entry-2:0]   arr_w_din,
    input  logic [2*width-bit_entry-2:0]   arr_r_dout,
    input  logic [2*width-bit_entry-2:0]   arr_w_dout
);

    localparam int unsigned T     = width - bit_entry - 2;
    localparam int unsigned E     = 1 + T + width;
    localparam int unsigned DEPTH = 2 ** fifo_log2;

    typedef enum logic {
        FLUSH,
        RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [bit_entry-1:0]   fcnt_q, fcnt_d;
    logic [fifo_log2-1:0]   wptr_q, wptr_d;
    logic [fifo_log2-1:0]   rptr_q, rptr_d;
    logic [fifo_log2:0]     occ_q, occ_d;

    // FIFO slots keep pc[width-1:2]; the byte-offset bits never reach the array.
    logic [width-3:0]       fpc_q  [DEPTH];
    logic [width-1:0]       ftgt_q [DEPTH];
    logic                   ftk_q  [DEPTH];

    logic                   run;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic [width-3:0]       h_pc;
    logic [width-1:0]       h_tgt;
    logic                   h_tk;
    logic [bit_entry-1:0]   h_idx;
    logic [T-1:0]           h_tag;
    logic                   w_valid;
    logic [T-1:0]           w_tag;
    logic                   unused_bits;

    assign unused_bits = ^{lkp_pc[1:0], upd_pc[1:0], arr_w_dout[width-1:0]};

    assign run       = (state_q == RUN);
    assign busy      = (state_q == FLUSH);
    assign full      = (occ_q == (fifo_log2+1)'(DEPTH));
    assign empty     = (occ_q == '0);
    assign upd_ready = run && !full;
    assign push      = upd_valid && upd_ready && !flush_req;
    assign pop       = run && !empty && !flush_req;

    assign h_pc    = fpc_q[rptr_q];
    assign h_tgt   = ftgt_q[rptr_q];
    assign h_tk    = ftk_q[rptr_q];
    assign h_idx   = h_pc[bit_entry-1:0];
    assign h_tag   = h_pc[width-3:bit_entry];
    assign w_valid = arr_w_dout[E-1];
    assign w_tag   = arr_w_dout[E-2 -: T];

    // Lookup path is purely combinational; the array bypass covers same-cycle writes.
    assign arr_r_index = lkp_pc[bit_entry+1:2];
    assign pred_hit    = run && arr_r_dout[E-1]
                         && (arr_r_dout[E-2 -: T] == lkp_pc[width-1:bit_entry+2]);
    assign pred_target = pred_hit ? arr_r_dout[width-1:0] : '0;

    always_comb begin
        arr_load    = 1'b0;
        arr_w_index = '0;
        arr_w_din   = '0;
        if (!run) begin
            arr_load    = 1'b1;
            arr_w_index = fcnt_q;
        end else if (pop) begin
            arr_w_index = h_idx;
            if (h_tk) begin
                arr_load  = 1'b1;
                arr_w_din = {1'b1, h_tag, h_tgt};
            end else begin
                arr_load  = w_valid && (w_tag == h_tag);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        occ_d   = occ_q;
        if (flush_req) begin
            state_d = FLUSH;
            fcnt_d  = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            occ_d   = '0;
        end else if (!run) begin
            fcnt_d = fcnt_q + 1'b1;
            if (fcnt_q == '1) begin
                state_d = RUN;
            end
        end else begin
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FLUSH;
            fcnt_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            occ_q   <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fpc_q[wptr_q]  <= upd_pc[width-1:2];
            ftgt_q[wptr_q] <= upd_target;
            ftk_q[wptr_q]  <= upd_taken;
        end
    end

endmodule
